logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
- Shares one combinational logic_gates unit between NUM_REQ requesters, e.g. the issue stage and a debug/microcode port.
- Round-robin arbitration over valid/ready request channels.
- Registers the result into a single-entry response slot with a valid/ready handshake, returned with the requester ID.
- Sits between the issue logic and writeback in the simple_processor datapath.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), width of the requester ID tag; derived, not overridden.

Ports:
- clk_i  input  1  system clock.
- arst_ni  input  1  asynchronous, active-low reset.
- req_valid_i  input  NUM_REQ  per-requester request valid.
- req_ready_o  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_rs1_i  input  NUM_REQ*DATA_WIDTH  operand 1 per requester; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_rs2_i  input  NUM_REQ*DATA_WIDTH  operand 2 per requester; same packing.
- req_op_i  input  NUM_REQ*$bits(func_t)  opcode per requester; same packing.
- rsp_valid_o  output  1  response slot holds a result.
- rsp_ready_i  input  1  consumer accepts the response.
- rsp_data_o  output  DATA_WIDTH  registered result.
- rsp_id_o  output  ID_W  index of the requester that produced rsp_data_o.
- rsp_err_o  output  1  result came from an unsupported opcode.

Behaviour:
- Reset (arst_ni low, asynchronous): rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, rsp_err_o=0, rr_ptr=0. req_ready_o is combinationally 0 while rsp_valid_o=0 and no request is valid.
- accept = !rsp_valid_o || rsp_ready_i. This is combinational, so the pipeline gives full throughput with back-to-back transfers.
- Arbitration:
  - Search req_valid_i starting at rr_ptr, ascending index, wrapping at NUM_REQ-1 -> 0. The first hit is the grant g.
  - req_ready_o[g] = accept. All other ready bits are 0.
  - No valid requester -> no grant, all ready bits 0.
- Handshake on requester g (valid && ready):
  - The selected operands and opcode feed the logic_gates instance.
  - Next edge: rsp_valid_o=1, rsp_data_o=gate output, rsp_id_o=g, rsp_err_o as defined below.
  - rr_ptr = (g+1) mod NUM_REQ.
- Latency: exactly 1 clock from request handshake to rsp_valid_o=1.
- Supported opcodes: 4'b0101 AND, 4'b1101 OR, 4'b1111 XOR, 4'b0111 NOT (rs1 only).
- Any other opcode is still accepted and consumes the grant. It produces rsp_data_o=0 (never Z/X) and rsp_err_o=1.
- Response consumed with no new handshake in the same cycle: rsp_valid_o->0. Data, id and err hold their last values.
- Simultaneous consume and new handshake in one cycle: the slot is overwritten, rsp_valid_o stays 1, and no bubble is inserted.
- Backpressure (rsp_valid_o=1, rsp_ready_i=0): all req_ready_o=0, and rsp_* stay stable until consumed. rr_ptr does not move without a handshake.
- Requesters must hold valid and payload stable until ready. Withdrawing valid early is protocol misuse; the arbiter simply re-arbitrates.
- Reset asserted mid-transfer drops any pending response. There is no replay.
- Fairness: with all requesters continuously valid and rsp_ready_i=1, grants rotate 0,1,...,NUM_REQ-1,0,...

Decomposition:
- sp_pkg: add localparams LOGIC_AND=4'b0101, LOGIC_OR=4'b1101, LOGIC_XOR=4'b1111, LOGIC_NOT=4'b0111.
- sp_pkg: add function is_logic_op(func_t) returning 1 for those four codes.
- DATA_WIDTH and func_t are reused from sp_pkg unchanged.
- Sub-module: one instance of the existing logic_gates. Its output is muxed to 0 when is_logic_op is false.
- Round-robin pick is a local function; no separate arbiter module.

Test Plan:
- Reset: arst_ni=0 mid-cycle with rsp_valid_o=1 -> all rsp_* and rr_ptr go to 0 immediately, without waiting for a clock edge.
- Single request: NUM_REQ=2, req0 AND rs1=32'hF0F0_1234, rs2=32'h0FF0_FFFF -> next cycle rsp_valid=1, data=32'h00F0_1234, id=0, err=0.
- Round-robin: both valid every cycle, XOR on req0, OR on req1, rsp_ready=1 -> ids 0,1,0,1 on consecutive cycles with no bubbles.
- Backpressure: rsp_ready=0 for 3 cycles while both requesters are valid -> req_ready_o=2'b00, rsp_* stable. When rsp_ready rises, the next grant goes to the requester after the last winner.
- Illegal opcode: req1 op=4'b0000 -> req1 handshakes, rsp data=0, err=1, id=1, and rr_ptr advances to 0.
- NOT with back-to-back consume: req0 NOT rs1=32'h0000_00FF with rsp_ready=1 while a prior response is in the slot -> the slot updates in the same cycle to 32'hFFFF_FF00 with rsp_valid continuously 1.

Source files
------------

// File: rtl/sp_pkg.sv
// rtl/sp_pkg.sv - shared datapath types, logic opcodes and opcode classifier
package sp_pkg;

    localparam int DATA_WIDTH = 32;

    typedef logic [3:0] func_t;

    localparam int FUNC_W = $bits(func_t);

    localparam func_t LOGIC_AND = 4'b0101;
    localparam func_t LOGIC_OR  = 4'b1101;
    localparam func_t LOGIC_XOR = 4'b1111;
    localparam func_t LOGIC_NOT = 4'b0111;

    function automatic logic is_logic_op(input func_t op);
        return (op == LOGIC_AND) || (op == LOGIC_OR) ||
               (op == LOGIC_XOR) || (op == LOGIC_NOT);
    endfunction

endpackage

// File: rtl/logic_gates.sv
// rtl/logic_gates.sv - combinational bitwise logic unit
module logic_gates
    import sp_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    input  func_t                 op,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        unique case (op)
            LOGIC_AND: result = rs1 & rs2;
            LOGIC_OR:  result = rs1 | rs2;
            LOGIC_XOR: result = rs1 ^ rs2;
            LOGIC_NOT: result = ~rs1;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin sharing of one logic_gates unit with a registered response slot
module logic_unit_arbiter
    import sp_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          arst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_rs1_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_rs2_i,
    input  logic [NUM_REQ*FUNC_W-1:0]     req_op_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic [ID_W-1:0]               rsp_id_o,
    output logic                          rsp_err_o
);

    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       grant_idx;
    logic                  grant_hit;
    logic                  accept;
    logic                  handshake;
    logic [DATA_WIDTH-1:0] sel_rs1;
    logic [DATA_WIDTH-1:0] sel_rs2;
    func_t                 sel_op;
    logic [DATA_WIDTH-1:0] gate_result;
    logic                  sel_legal;

    assign accept    = !rsp_valid_o || rsp_ready_i;
    assign handshake = grant_hit && accept;

    // Walk offsets from the far end so the requester closest to rr_ptr wins last.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (req_valid_i[idx]) begin
                grant_hit = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (grant_hit) begin
            req_ready_o[grant_idx] = accept;
        end
    end

    assign sel_rs1   = req_rs1_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_rs2   = req_rs2_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_op    = req_op_i[int'(grant_idx)*FUNC_W +: FUNC_W];
    assign sel_legal = is_logic_op(sel_op);

    logic_gates u_logic_gates (
        .rs1    (sel_rs1),
        .rs2    (sel_rs2),
        .op     (sel_op),
        .result (gate_result)
    );

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_id_o    <= '0;
            rsp_err_o   <= 1'b0;
            rr_ptr      <= '0;
        end else if (handshake) begin
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= sel_legal ? gate_result : '0;
            rsp_id_o    <= grant_idx;
            rsp_err_o   <= !sel_legal;
            rr_ptr      <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (rsp_ready_i) begin
            // Payload fields keep their last values once the slot drains.
            rsp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - scoreboard bench for logic_unit_arbiter
module tb_logic_unit_arbiter;
    import sp_pkg::*;

    localparam int NR = 2;

    logic                     clk = 1'b0;
    logic                     arst_n;
    logic [NR-1:0]            req_valid;
    logic [NR-1:0]            req_ready;
    logic [NR*DATA_WIDTH-1:0] req_rs1;
    logic [NR*DATA_WIDTH-1:0] req_rs2;
    logic [NR*FUNC_W-1:0]     req_op;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_WIDTH-1:0]    rsp_data;
    logic [0:0]               rsp_id;
    logic                     rsp_err;

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        logic                  id;
        logic                  err;
    } exp_t;

    exp_t                  sb[$];
    logic [DATA_WIDTH-1:0] exp_data [NR];
    logic                  exp_err  [NR];
    int                    total = 0;
    int                    bad   = 0;

    logic_unit_arbiter #(.NUM_REQ(NR)) dut (
        .clk_i       (clk),
        .arst_ni     (arst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_rs1_i   (req_rs1),
        .req_rs2_i   (req_rs2),
        .req_op_i    (req_op),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_id_o    (rsp_id),
        .rsp_err_o   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b,
                           input func_t op, input logic [31:0] ed, input logic ee);
        req_rs1[k*DATA_WIDTH +: DATA_WIDTH] = a;
        req_rs2[k*DATA_WIDTH +: DATA_WIDTH] = b;
        req_op[k*FUNC_W +: FUNC_W]          = op;
        exp_data[k]                         = ed;
        exp_err[k]                          = ee;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Request-side observer: every accepted request enqueues its expected response.
    always @(negedge clk) begin
        if (arst_n) begin
            for (int k = 0; k < NR; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    sb.push_back('{data: exp_data[k], id: 1'(k), err: exp_err[k]});
                end
            end
        end
    end

    // Response-side monitor: every consumed response is checked against the queue head.
    always @(negedge clk) begin
        if (arst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp", 64'(rsp_data), 64'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_data", 64'(rsp_data), 64'(e.data));
                chk("sb_id",   64'(rsp_id),   64'(e.id));
                chk("sb_err",  64'(rsp_err),  64'(e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rr_exp [4];
        rr_exp = '{2'b10, 2'b01, 2'b10, 2'b01};

        arst_n    = 1'b0;
        req_valid = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < NR; k++) begin
            exp_data[k] = '0;
            exp_err[k]  = 1'b0;
        end
        repeat (2) next_cycle();
        chk("rst_valid", 64'(rsp_valid), 64'h0);
        chk("rst_data",  64'(rsp_data),  64'h0);
        chk("rst_id",    64'(rsp_id),    64'h0);
        chk("rst_err",   64'(rsp_err),   64'h0);
        chk("rst_ready", 64'(req_ready), 64'h0);
        arst_n = 1'b1;

        // Single AND request on requester 0, one-cycle latency.
        set_req(0, 32'hF0F0_1234, 32'h0FF0_FFFF, LOGIC_AND, 32'h00F0_1234, 1'b0);
        req_valid = 2'b01;
        @(negedge clk);
        chk("single_ready", 64'(req_ready), 64'h1);
        chk("single_pre_valid", 64'(rsp_valid), 64'h0);
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk);
        chk("single_lat_valid", 64'(rsp_valid), 64'h1);
        chk("single_data", 64'(rsp_data), 64'h00F0_1234);
        chk("single_id",   64'(rsp_id),   64'h0);
        next_cycle();

        // Round-robin with both requesters valid; pointer sits at 1 after the single request.
        set_req(0, 32'hA5A5_A5A5, 32'hFFFF_0000, LOGIC_XOR, 32'h5A5A_A5A5, 1'b0);
        set_req(1, 32'h1200_0034, 32'h0000_5600, LOGIC_OR,  32'h1200_5634, 1'b0);
        req_valid = 2'b11;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rr_ready", 64'(req_ready), 64'(rr_exp[c]));
            if (c > 0) chk("rr_no_bubble", 64'(rsp_valid), 64'h1);
            next_cycle();
        end

        // Backpressure: slot holds the last XOR result from requester 0.
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_ready", 64'(req_ready), 64'h0);
            chk("bp_valid", 64'(rsp_valid), 64'h1);
            chk("bp_data",  64'(rsp_data),  64'h5A5A_A5A5);
            chk("bp_id",    64'(rsp_id),    64'h0);
            next_cycle();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(req_ready), 64'h2);
        next_cycle();

        // Unsupported opcode on requester 1.
        set_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b1);
        req_valid = 2'b10;
        @(negedge clk);
        chk("ill_ready", 64'(req_ready), 64'h2);
        next_cycle();

        // NOT on requester 0 overwrites the illegal-op result in the same cycle.
        set_req(0, 32'h0000_00FF, 32'h1234_5678, LOGIC_NOT, 32'hFFFF_FF00, 1'b0);
        req_valid = 2'b11;
        @(negedge clk);
        chk("ill_ptr_ready", 64'(req_ready), 64'h1);
        chk("ill_data", 64'(rsp_data), 64'h0);
        chk("ill_err",  64'(rsp_err),  64'h1);
        chk("ill_id",   64'(rsp_id),   64'h1);
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk);
        chk("not_valid", 64'(rsp_valid), 64'h1);
        chk("not_data",  64'(rsp_data),  64'hFFFF_FF00);
        next_cycle();
        @(negedge clk);
        chk("drain_valid", 64'(rsp_valid), 64'h0);
        chk("drain_hold",  64'(rsp_data),  64'hFFFF_FF00);
        next_cycle();

        // Asynchronous reset while a response is pending.
        set_req(0, 32'hF0F0_1234, 32'h0FF0_FFFF, LOGIC_AND, 32'h00F0_1234, 1'b0);
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        next_cycle();
        req_valid = 2'b00;
        #1;
        chk("pre_rst_valid", 64'(rsp_valid), 64'h1);
        arst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_valid", 64'(rsp_valid), 64'h0);
        chk("arst_data",  64'(rsp_data),  64'h0);
        chk("arst_id",    64'(rsp_id),    64'h0);
        chk("arst_err",   64'(rsp_err),   64'h0);
        next_cycle();
        arst_n    = 1'b1;
        rsp_ready = 1'b1;
        set_req(1, 32'h1200_0034, 32'h0000_5600, LOGIC_OR, 32'h1200_5634, 1'b0);
        req_valid = 2'b11;
        @(negedge clk);
        chk("arst_ptr_ready", 64'(req_ready), 64'h1);
        next_cycle();
        req_valid = 2'b00;
        repeat (3) next_cycle();
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
